// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants and state type for the 4-requester round-robin mux arbiter.
package mux4_rr_arbiter_pkg;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/consumer bundle around the arbiter: requests, data words, grant/select and output port.
interface mux4_rr_arbiter_if
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int unsigned DW = 9
) ();

  logic [NREQ-1:0]  req;
  logic [DW-1:0]    d0;
  logic [DW-1:0]    d1;
  logic [DW-1:0]    d2;
  logic [DW-1:0]    d3;
  logic [NREQ-1:0]  grant;
  logic [SEL_W-1:0] sel;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             out_ready;

  modport master (
    input  req, d0, d1, d2, d3, out_ready,
    output grant, sel, out_valid, out_data
  );

  modport slave (
    output req, d0, d1, d2, d3, out_ready,
    input  grant, sel, out_valid, out_data
  );

endinterface

// File: rtl/mux4.sv
// Team 4:1 select mux; only the selected input reaches y.
module mux4 #(
  parameter int unsigned W = 9
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [W-1:0] y
);

  always_comb begin
    y = d0;
    case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first requester after last_ptr, wrapping, optionally excluding one index.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] last_ptr,
  input  logic             excl_en,
  input  logic [SEL_W-1:0] excl_idx,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Offset NREQ wraps back onto last_ptr itself, so a lone requester can re-win.
  always_comb begin
    found = 1'b0;
    idx   = last_ptr;
    cand  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = last_ptr + SEL_W'(k);
      if (!found && req[cand] && !(excl_en && (cand == excl_idx))) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for the shared 4:1 mux with a bounded burst per grant and zero-bubble handover.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int unsigned DW       = 9,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mux4_rr_arbiter_if.master  bus
);

  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  arb_state_t        state;
  logic [SEL_W-1:0]  sel_q;
  logic [SEL_W-1:0]  last_ptr;
  logic [NREQ-1:0]   grant_q;
  logic [HOLD_W-1:0] hold_cnt;

  logic              out_valid_c;
  logic              xfer_c;
  logic              drop_c;
  logic              release_c;
  logic              found_c;
  logic [SEL_W-1:0]  pick_ptr_c;
  logic [SEL_W-1:0]  pick_idx_c;
  logic [DW-1:0]     mux_y_c;

  assign out_valid_c = (state == GRANT) && bus.req[sel_q];
  assign xfer_c      = out_valid_c && bus.out_ready;
  assign drop_c      = (state == GRANT) && !bus.req[sel_q];
  assign release_c   = drop_c || (xfer_c && (hold_cnt == HOLD_W'(MAX_HOLD - 1)));

  // On release the pointer advances to the releasing owner before the next pick.
  assign pick_ptr_c  = release_c ? sel_q : last_ptr;

  rr_pick4 u_pick (
    .req      (bus.req),
    .last_ptr (pick_ptr_c),
    .excl_en  (drop_c),
    .excl_idx (sel_q),
    .found    (found_c),
    .idx      (pick_idx_c)
  );

  mux4 #(.W(DW)) u_mux (
    .sel (sel_q),
    .d0  (bus.d0),
    .d1  (bus.d1),
    .d2  (bus.d2),
    .d3  (bus.d3),
    .y   (mux_y_c)
  );

  assign bus.grant     = grant_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = mux_y_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel_q    <= '0;
      grant_q  <= '0;
      hold_cnt <= '0;
      last_ptr <= SEL_W'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found_c) begin
            state    <= GRANT;
            sel_q    <= pick_idx_c;
            grant_q  <= NREQ'(1) << pick_idx_c;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (release_c) begin
            last_ptr <= sel_q;
            hold_cnt <= '0;
            if (found_c) begin
              sel_q   <= pick_idx_c;
              grant_q <= NREQ'(1) << pick_idx_c;
            end else begin
              state   <= IDLE;
              grant_q <= '0;
            end
          end else if (xfer_c) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: owner/pointer model checked every cycle plus directed literal checks.
module tb_mux4_rr_arbiter;

  localparam int unsigned DW       = 9;
  localparam int          MAX_HOLD = 4;

  logic clk;
  logic rst_n;

  mux4_rr_arbiter_if #(.DW(DW)) bus ();

  mux4_rr_arbiter #(.DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: current owner (-1 when nobody holds the mux), transfers in this grant, last releaser.
  int m_owner;
  int m_cnt;
  int m_ptr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int ptr, input int excl);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (ptr + k) % 4;
      if (r[c] && c != excl) return c;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] dval(input int o);
    case (o)
      0: return bus.d0;
      1: return bus.d1;
      2: return bus.d2;
      default: return bus.d3;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1;
      m_cnt   <= 0;
      m_ptr   <= 3;
    end else begin : upd
      int  o, c, p, nx;
      bit  xfer, drop;
      o = m_owner;
      c = m_cnt;
      p = m_ptr;
      if (o < 0) begin
        nx = pick(bus.req, p, -1);
        if (nx >= 0) begin
          o = nx;
          c = 0;
        end
      end else begin
        drop = !bus.req[o];
        xfer = !drop && bus.out_ready;
        if (drop || (xfer && c == MAX_HOLD - 1)) begin
          p = o;
          o = pick(bus.req, p, drop ? o : -1);
          c = 0;
        end else if (xfer) begin
          c = c + 1;
        end
      end
      m_owner <= o;
      m_cnt   <= c;
      m_ptr   <= p;
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    logic [3:0] eg;
    bit         ev;
    eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    ev = (m_owner >= 0) && bus.req[m_owner];
    chk("model_grant", 32'(bus.grant), 32'(eg));
    chk("model_out_valid", 32'(bus.out_valid), 32'(ev));
    if (m_owner >= 0) chk("model_sel", 32'(bus.sel), 32'(m_owner));
    if (ev) chk("model_out_data", 32'(bus.out_data), 32'(dval(m_owner)));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req       = 4'b0000;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    int         cycles;
  } vec_t;

  vec_t vecs[10];

  initial begin
    rst_n         = 1'b0;
    bus.req       = 4'b0000;
    bus.out_ready = 1'b0;
    bus.d0        = 9'h011;
    bus.d1        = 9'h0C2;
    bus.d2        = 9'h1A5;
    bus.d3        = 9'h133;

    // Reset values
    tick();
    tick();
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_sel", 32'(bus.sel), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h011);
    rst_n = 1'b1;

    // Single requester: one-cycle grant latency, then continuous re-grant to itself
    tick();
    bus.req       = 4'b0100;
    bus.out_ready = 1'b1;
    tick();
    chk("single_grant", 32'(bus.grant), 32'h4);
    chk("single_sel", 32'(bus.sel), 32'h2);
    chk("single_data", 32'(bus.out_data), 32'h1A5);
    chk("single_valid", 32'(bus.out_valid), 32'h1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("single_hold_valid", 32'(bus.out_valid), 32'h1);
      chk("single_hold_grant", 32'(bus.grant), 32'h4);
    end

    // Fairness: four transfers each, in order, no bubbles
    do_reset();
    bus.req = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("fair_sel", 32'(bus.sel), 32'((k / 4) % 4));
      chk("fair_valid", 32'(bus.out_valid), 32'h1);
    end

    // Backpressure freezes requester 1's burst; 4 transfers total before rotating to 2
    do_reset();
    bus.req = 4'b0110;
    tick();
    chk("bp_grant", 32'(bus.grant), 32'h2);
    tick();
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_sel", 32'(bus.sel), 32'h1);
      chk("bp_data", 32'(bus.out_data), 32'h0C2);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_resume_sel", 32'(bus.sel), 32'h1);
    tick();
    chk("bp_rotate_sel", 32'(bus.sel), 32'h2);
    chk("bp_rotate_grant", 32'(bus.grant), 32'h4);

    // Early release: requester 0 drops after two transfers
    do_reset();
    bus.req = 4'b0011;
    tick();
    chk("early_sel0", 32'(bus.sel), 32'h0);
    tick();
    tick();
    bus.req = 4'b0010;
    #1;
    chk("early_drop_valid", 32'(bus.out_valid), 32'h0);
    tick();
    chk("early_sel1", 32'(bus.sel), 32'h1);
    chk("early_grant1", 32'(bus.grant), 32'h2);
    chk("early_valid1", 32'(bus.out_valid), 32'h1);

    // Wrap-around: 0, then 3, then 0 again
    do_reset();
    bus.req = 4'b1001;
    tick();
    chk("wrap_grant0", 32'(bus.grant), 32'h1);
    bus.req = 4'b1000;
    tick();
    chk("wrap_grant3", 32'(bus.grant), 32'h8);
    bus.req = 4'b0001;
    tick();
    chk("wrap_grant0b", 32'(bus.grant), 32'h1);

    // Asynchronous reset mid-burst
    do_reset();
    bus.req = 4'b1111;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_grant", 32'(bus.grant), 32'h0);
    chk("arst_sel", 32'(bus.sel), 32'h0);
    chk("arst_valid", 32'(bus.out_valid), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_first_grant", 32'(bus.grant), 32'h1);

    // Mixed traffic checked by the model only
    vecs[0] = '{4'b1010, 1'b1, 6};
    vecs[1] = '{4'b1010, 1'b0, 3};
    vecs[2] = '{4'b0110, 1'b1, 5};
    vecs[3] = '{4'b0000, 1'b1, 2};
    vecs[4] = '{4'b1000, 1'b1, 7};
    vecs[5] = '{4'b1101, 1'b1, 9};
    vecs[6] = '{4'b0101, 1'b0, 2};
    vecs[7] = '{4'b0001, 1'b1, 3};
    vecs[8] = '{4'b1111, 1'b1, 10};
    vecs[9] = '{4'b0011, 1'b1, 6};
    for (int v = 0; v < 10; v++) begin
      bus.req       = vecs[v].req;
      bus.out_ready = vecs[v].rdy;
      for (int c = 0; c < vecs[v].cycles; c++) tick();
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
